// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Each byte received is presented on `data`
// with a one-cycle data_valid strobe. A stop bit sampled low gives a one-cycle frame_error strobe.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);
    // state     | meaning
    // IDLE      | line idle, waiting for rx_s to fall
    // START     | checking start bit at mid-bit, rejects glitches
    // DATA      | sampling 8 data bits at mid-bit
    // STOP      | sampling stop bit at mid-bit
    // WAIT_HIGH | bad stop bit seen, waiting for line to return high
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             rx_meta_q, rx_s_q;

    wire half_tc = (cnt_q == CNT_W'(HALF_BIT - 1));
    wire bit_tc  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= RxD;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (half_tc) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (bit_tc) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_tc) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) stays here, so it yields a single error pulse.
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period (16 clocks per bit).
module tb_uart_rx;
    localparam int CLK_FREQ  = 16;
    localparam int BAUD_RATE = 1;
    localparam int CPB       = 16;
    localparam int HALF      = 8;
    // Pin driven just after a posedge, capture on the next posedge, plus two sync stages.
    localparam int LAT       = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid, frame_error, busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst(rst), .RxD(RxD), .data(data),
        .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, last_dv_cyc = 0;
    logic [7:0] last_dv_data = 8'h00;
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt       = dv_cnt + 1;
            last_dv_cyc  = cyc;
            last_dv_data = data;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_error) both_cnt = both_cnt + 1;
    end

    int vec = 0, errs = 0;

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        RxD = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        int         idle_after;
    } frame_vec_t;

    frame_vec_t tbl[6];
    int         t0, n0, f0;
    logic [7:0] d0;

    initial begin
        tbl[0] = '{8'hEF, 2 * CPB};
        tbl[1] = '{8'h00, 0};
        tbl[2] = '{8'hFF, CPB};
        tbl[3] = '{8'h5A, 3};
        tbl[4] = '{8'h01, 0};
        tbl[5] = '{8'h80, CPB};

        rst = 1'b1;
        RxD = 1'b1;
        tick(3);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(data_valid), 0);
        check("reset_ferr", int'(frame_error), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);

        // Frames from the table: 00 -> FF and 01 -> 80 are sent with no idle between them.
        for (int i = 0; i < 6; i++) begin
            n0 = dv_cnt;
            f0 = fe_cnt;
            send_frame(tbl[i].byte_v, 1'b1, t0);
            #1;
            check($sformatf("vec%0d_pulses", i), dv_cnt - n0, 1);
            check($sformatf("vec%0d_data", i), int'(last_dv_data), int'(tbl[i].byte_v));
            check($sformatf("vec%0d_latency", i), last_dv_cyc - t0, LAT);
            check($sformatf("vec%0d_no_ferr", i), fe_cnt - f0, 0);
            tick(tbl[i].idle_after);
        end
        tick(2);

        // Three-clock low glitch on the idle line must be rejected at mid start bit.
        n0 = dv_cnt;
        d0 = data;
        RxD = 1'b0;
        tick(3);
        RxD = 1'b1;
        #1;
        check("glitch_busy_set", int'(busy), 1);
        tick(HALF - 1);
        #1;
        check("glitch_busy_held", int'(busy), 1);
        tick(1);
        #1;
        check("glitch_busy_drop", int'(busy), 0);
        tick(CPB);
        check("glitch_no_pulse", dv_cnt - n0, 0);
        check("glitch_data_kept", int'(data), int'(d0));

        // Bad stop bit followed by a break of three bit times gives a single error pulse.
        n0 = dv_cnt;
        f0 = fe_cnt;
        d0 = data;
        send_frame(8'hA5, 1'b0, t0);
        RxD = 1'b0;
        tick(3 * CPB);
        check("break_busy", int'(busy), 1);
        RxD = 1'b1;
        tick(2 * CPB);
        #1;
        check("ferr_pulses", fe_cnt - f0, 1);
        check("ferr_no_valid", dv_cnt - n0, 0);
        check("ferr_data_kept", int'(data), int'(d0));
        check("ferr_idle_after", int'(busy), 0);

        n0 = dv_cnt;
        send_frame(8'h3C, 1'b1, t0);
        #1;
        check("after_ferr_pulses", dv_cnt - n0, 1);
        check("after_ferr_data", int'(last_dv_data), 8'h3C);
        check("after_ferr_latency", last_dv_cyc - t0, LAT);
        tick(CPB);

        // Reset pulse in the middle of bit 4 of 0x55 aborts the frame.
        n0 = dv_cnt;
        f0 = fe_cnt;
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) drive_bit(((8'h55 >> i) & 8'h01) != 8'h00);
        RxD = 1'b1;
        tick(HALF);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_ferr", int'(frame_error), 0);
        tick(2 * CPB);
        check("rst_no_pulse", dv_cnt - n0, 0);
        check("rst_no_ferr", fe_cnt - f0, 0);

        n0 = dv_cnt;
        send_frame(8'h81, 1'b1, t0);
        #1;
        check("after_rst_pulses", dv_cnt - n0, 1);
        check("after_rst_data", int'(data), 8'h81);
        check("after_rst_latency", last_dv_cyc - t0, LAT);
        tick(CPB);

        check("valid_and_ferr_together", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
